// File: rtl/oled_source_arbiter.sv
// OLED source arbiter: picks which colour generator owns the display,
// switching only on frame boundaries with optional blank frames between.
module oled_source_arbiter #(
    parameter int          STABLE_CYCLES = 1000,
    parameter int          BLANK_FRAMES  = 2,
    parameter logic [15:0] BLANK_COLOUR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  task_req,
    input  logic        grp_req,
    input  logic        celebrate_set,
    input  logic        right_click,
    input  logic        frame_begin,
    input  logic [15:0] colour_a,
    input  logic [15:0] colour_b,
    input  logic [15:0] colour_c,
    input  logic [15:0] colour_d,
    input  logic [15:0] colour_cel,
    input  logic [15:0] colour_grp,
    output logic [15:0] oled_colour,
    output logic [2:0]  active_src,
    output logic        switching,
    output logic        seg_en,
    output logic        canvas_reset
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [BW-1:0] BLAST = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

    logic [1:0]    state, state_n;
    logic [2:0]    target, target_n, act_n;
    logic [2:0]    cand, prev_cand, stable_cand, stable_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          cel_flag, cel_n;
    logic          same, accept;

    always_comb begin
        cand = 3'd7;
        if (task_req[0])               cand = 3'd0;
        else if (task_req[1])          cand = 3'd1;
        else if (task_req[2])          cand = 3'd2;
        else if (task_req[3])          cand = 3'd3;
        else if (cel_flag && grp_req)  cand = 3'd4;
        else if (grp_req)              cand = 3'd5;
    end

    // cnt holds (cycles the candidate has been held) - 1, saturating
    always_comb begin
        same   = (cand == prev_cand);
        accept = (STABLE_CYCLES <= 1) ||
                 (same && (int'(cnt) + 1 >= STABLE_CYCLES - 1));
        if (!same)               cnt_n = '0;
        else if (cnt == CNT_MAX) cnt_n = cnt;
        else                     cnt_n = cnt + CW'(1);
        stable_n = accept ? cand : stable_cand;
    end

    always_comb begin
        cel_n = cel_flag;
        if (task_req != 4'd0 || !grp_req)
            cel_n = 1'b0;
        else if (celebrate_set && state == S_RUN && active_src == 3'd5)
            cel_n = 1'b1;
    end

    always_comb begin
        state_n  = state;
        act_n    = active_src;
        target_n = target;
        bcnt_n   = bcnt;
        case (state)
            S_RUN: begin
                if (stable_cand != active_src) begin
                    target_n = stable_cand;
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                target_n = stable_cand;
                if (stable_cand == active_src) begin
                    state_n = S_RUN;
                end else if (frame_begin) begin
                    if (BLANK_FRAMES == 0) begin
                        act_n   = target;
                        state_n = S_RUN;
                    end else begin
                        bcnt_n  = '0;
                        state_n = S_BLANK;
                    end
                end
            end
            S_BLANK: begin
                target_n = stable_cand;
                if (frame_begin) begin
                    if (bcnt == BLAST) begin
                        act_n   = target;
                        state_n = S_RUN;
                    end else begin
                        bcnt_n = bcnt + BW'(1);
                    end
                end
            end
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RUN;
            active_src   <= 3'd7;
            target       <= 3'd7;
            prev_cand    <= 3'd7;
            stable_cand  <= 3'd7;
            cnt          <= '0;
            bcnt         <= '0;
            cel_flag     <= 1'b0;
            seg_en       <= 1'b0;
            canvas_reset <= 1'b1;
        end else begin
            state        <= state_n;
            active_src   <= act_n;
            target       <= target_n;
            prev_cand    <= cand;
            stable_cand  <= stable_n;
            cnt          <= cnt_n;
            bcnt         <= bcnt_n;
            cel_flag     <= cel_n;
            seg_en       <= (state_n == S_RUN) &&
                            (act_n == 3'd4 || act_n == 3'd5);
            canvas_reset <= (state_n == S_RUN && act_n == 3'd5) ?
                            right_click : 1'b1;
        end
    end

    assign switching = (state != S_RUN);

    always_comb begin
        if (state == S_BLANK) begin
            oled_colour = BLANK_COLOUR;
        end else begin
            case (active_src)
                3'd0:    oled_colour = colour_a;
                3'd1:    oled_colour = colour_b;
                3'd2:    oled_colour = colour_c;
                3'd3:    oled_colour = colour_d;
                3'd4:    oled_colour = colour_cel;
                3'd5:    oled_colour = colour_grp;
                default: oled_colour = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_source_arbiter.sv
// Random + directed bench for oled_source_arbiter against a timestamp/
// frame-countdown reference model; two instances cover blank and no-blank.
module tb_oled_source_arbiter;

    localparam int FP = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  task_req;
    logic        grp_req, celebrate_set, right_click, frame_begin;
    logic [15:0] colour_a, colour_b, colour_c, colour_d;
    logic [15:0] colour_cel, colour_grp;

    logic [15:0] oc [2];
    logic [2:0]  as [2];
    logic        sw [2];
    logic        se [2];
    logic        cr [2];

    int          ps [2] = '{1000, 3};
    int          pb [2] = '{2, 0};
    logic [15:0] pc [2] = '{16'h0000, 16'hBEEF};

    // reference model: phase 0=run 1=wait 2=blank
    int m_act [2], m_tgt [2], m_ph [2], m_rem [2];
    int m_run [2], m_prev [2], m_stab [2];
    bit m_cel [2], m_seg [2], m_crst [2];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit fb_en = 1'b1;
    bit cel_once = 1'b0;
    bit cel_rand = 1'b0;

    always #5 clk = ~clk;

    oled_source_arbiter dut0 (
        .clk(clk), .rst_n(rst_n), .task_req(task_req), .grp_req(grp_req),
        .celebrate_set(celebrate_set), .right_click(right_click),
        .frame_begin(frame_begin), .colour_a(colour_a), .colour_b(colour_b),
        .colour_c(colour_c), .colour_d(colour_d), .colour_cel(colour_cel),
        .colour_grp(colour_grp), .oled_colour(oc[0]), .active_src(as[0]),
        .switching(sw[0]), .seg_en(se[0]), .canvas_reset(cr[0])
    );

    oled_source_arbiter #(
        .STABLE_CYCLES(3), .BLANK_FRAMES(0), .BLANK_COLOUR(16'hBEEF)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .task_req(task_req), .grp_req(grp_req),
        .celebrate_set(celebrate_set), .right_click(right_click),
        .frame_begin(frame_begin), .colour_a(colour_a), .colour_b(colour_b),
        .colour_c(colour_c), .colour_d(colour_d), .colour_cel(colour_cel),
        .colour_grp(colour_grp), .oled_colour(oc[1]), .active_src(as[1]),
        .switching(sw[1]), .seg_en(se[1]), .canvas_reset(cr[1])
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] src_colour(input int s);
        case (s)
            0:       return colour_a;
            1:       return colour_b;
            2:       return colour_c;
            3:       return colour_d;
            4:       return colour_cel;
            5:       return colour_grp;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int cand_of(input int i);
        if (task_req[0]) return 0;
        if (task_req[1]) return 1;
        if (task_req[2]) return 2;
        if (task_req[3]) return 3;
        if (m_cel[i] && grp_req) return 4;
        if (grp_req) return 5;
        return 7;
    endfunction

    task automatic model_reset(input int i);
        m_act[i] = 7; m_tgt[i] = 7; m_ph[i] = 0; m_rem[i] = 0;
        m_run[i] = 1; m_prev[i] = 7; m_stab[i] = 7;
        m_cel[i] = 0; m_seg[i] = 0; m_crst[i] = 1;
    endtask

    task automatic model_step(input int i);
        int c, run, nph, nact, ntgt, nrem;
        bit ncel;
        if (!rst_n) begin
            model_reset(i);
            return;
        end
        c   = cand_of(i);
        run = (c == m_prev[i]) ? m_run[i] + 1 : 1;
        if (run > 1000000) run = 1000000;
        ncel = m_cel[i];
        if (task_req != 0 || !grp_req) ncel = 0;
        else if (celebrate_set && m_ph[i] == 0 && m_act[i] == 5) ncel = 1;
        nph = m_ph[i]; nact = m_act[i]; ntgt = m_tgt[i]; nrem = m_rem[i];
        if (m_ph[i] == 0) begin
            if (m_stab[i] != m_act[i]) begin
                ntgt = m_stab[i];
                nph  = 1;
            end
        end else begin
            ntgt = m_stab[i];
            if (m_ph[i] == 1) begin
                if (m_stab[i] == m_act[i]) nph = 0;
                else if (frame_begin) begin
                    if (pb[i] == 0) begin
                        nph = 0; nact = m_tgt[i];
                    end else begin
                        nph = 2; nrem = pb[i];
                    end
                end
            end else if (frame_begin) begin
                nrem = m_rem[i] - 1;
                if (nrem == 0) begin
                    nph = 0; nact = m_tgt[i];
                end
            end
        end
        if (run >= ps[i]) m_stab[i] = c;
        m_prev[i] = c; m_run[i] = run; m_cel[i] = ncel;
        m_ph[i] = nph; m_act[i] = nact; m_tgt[i] = ntgt; m_rem[i] = nrem;
        m_seg[i]  = (nph == 0) && (nact == 4 || nact == 5);
        m_crst[i] = (nph == 0 && nact == 5) ? right_click : 1'b1;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("oled%0d", i), oc[i],
                (m_ph[i] == 2) ? pc[i] : src_colour(m_act[i]));
            chk($sformatf("act%0d", i), 16'(as[i]), 16'(m_act[i]));
            chk($sformatf("sw%0d", i), 16'(sw[i]), 16'(m_ph[i] != 0));
            chk($sformatf("seg%0d", i), 16'(se[i]), 16'(m_seg[i]));
            chk($sformatf("crst%0d", i), 16'(cr[i]), 16'(m_crst[i]));
        end
    endtask

    task automatic tick();
        colour_a   = 16'($urandom); colour_b   = 16'($urandom);
        colour_c   = 16'($urandom); colour_d   = 16'($urandom);
        colour_cel = 16'($urandom); colour_grp = 16'($urandom);
        right_click   = 1'($urandom);
        frame_begin   = fb_en && (cyc % FP == FP - 1);
        celebrate_set = cel_once || (cel_rand && $urandom_range(0, 149) == 0);
        cel_once = 1'b0;
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n = 1'b0; task_req = 4'd0; grp_req = 1'b0;
        celebrate_set = 1'b0; right_click = 1'b0; frame_begin = 1'b0;
        colour_a = '0; colour_b = '0; colour_c = '0; colour_d = '0;
        colour_cel = '0; colour_grp = '0;
        model_reset(0);
        model_reset(1);
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        grp_req = 1'b1;
        run(2200);
        chk("grp_act", 16'(as[0]), 16'd5);
        chk("grp_seg", 16'(se[0]), 16'd1);

        task_req = 4'b0010;
        run(999);
        task_req = 4'b0000;
        run(400);
        chk("glitch_act", 16'(as[0]), 16'd5);
        chk("glitch_sw", 16'(sw[0]), 16'd0);

        cel_once = 1'b1;
        run(2200);
        chk("cel_act", 16'(as[0]), 16'd4);
        task_req = 4'b0001;
        run(2200);
        chk("a_act", 16'(as[0]), 16'd0);
        chk("a_seg", 16'(se[0]), 16'd0);
        chk("a_crst", 16'(cr[0]), 16'd1);

        task_req = 4'b0000;
        run(2200);
        fb_en = 1'b0;
        task_req = 4'b0001;
        run(1100);
        chk("abort_wait", 16'(sw[0]), 16'd1);
        task_req = 4'b0000;
        run(1100);
        fb_en = 1'b1;
        chk("abort_act", 16'(as[0]), 16'd5);
        chk("abort_sw", 16'(sw[0]), 16'd0);

        cel_rand = 1'b1;
        for (int s = 0; s < 25; s++) begin
            case ($urandom_range(0, 4))
                0: begin task_req = 4'd0; grp_req = 1'b0; end
                1: begin task_req = 4'd0; grp_req = 1'b1; end
                2: begin task_req = 4'($urandom); grp_req = 1'($urandom); end
                3: begin task_req = 4'd1 << $urandom_range(0, 3); grp_req = 1'b1; end
                default: begin task_req = 4'd0; grp_req = 1'b1; cel_once = 1'b1; end
            endcase
            run($urandom_range(1, 1800));
        end
        cel_rand = 1'b0;

        task_req = 4'd0; grp_req = 1'b0;
        run(2500);
        task_req = 4'b1000;
        begin
            int k;
            k = 0;
            while (m_ph[0] != 2 && k < 3000) begin
                tick();
                k++;
            end
            if (m_ph[0] != 2) begin
                n_chk++; n_err++;
                $display("FAIL blank_timeout got %0d exp 2", m_ph[0]);
            end
        end
        run(50);
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk("rst_act", 16'(as[0]), 16'd7);
        chk("rst_oled", oc[0], 16'h0000);
        chk("rst_sw", 16'(sw[0]), 16'd0);
        chk("rst_crst", 16'(cr[0]), 16'd1);
        compare_all();
        tick();
        rst_n = 1'b1;
        run(200);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
